load_store_unit: RTL and testbench

Memory-stage front end of the RISC-V core: accepts one load or store per transaction from the execute stage and translates RISC-V `funct3` into the `data_mem` access encoding. It drives `data_mem` for the required cycles, registers the load result, and hands a response with destination register and fault status to write-back. Alignment and encoding are checked before any memory access; faulting requests never touch `data_mem`.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_decode.sv | 39 +++
 rtl/load_store_unit.sv | 113 +++++++++++
 tb/tb_load_store_unit.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: funct3 codes, data_mem access encodings,
// fault codes and FSM state values.
package lsu_pkg;

   localparam logic [2:0] F3Byte  = 3'b000;
   localparam logic [2:0] F3Half  = 3'b001;
   localparam logic [2:0] F3Word  = 3'b010;
   localparam logic [2:0] F3ByteU = 3'b100;
   localparam logic [2:0] F3HalfU = 3'b101;

   // mem_en layout: [3] signed, [2] write, [1:0] size
   localparam logic [3:0] EnNone = 4'b0000;
   localparam logic [3:0] EnSw   = 4'b0111;
   localparam logic [3:0] EnSh   = 4'b0110;
   localparam logic [3:0] EnSb   = 4'b0101;
   localparam logic [3:0] EnLw   = 4'b1011;
   localparam logic [3:0] EnLh   = 4'b1010;
   localparam logic [3:0] EnLhu  = 4'b0010;
   localparam logic [3:0] EnLb   = 4'b1001;
   localparam logic [3:0] EnLbu  = 4'b0001;

   localparam logic [1:0] SizeHalf = 2'b10;
   localparam logic [1:0] SizeWord = 2'b11;

   localparam logic [1:0] FaultNone     = 2'b00;
   localparam logic [1:0] FaultMisalign = 2'b01;
   localparam logic [1:0] FaultIllegal  = 2'b10;

   typedef logic [1:0] lsu_state_t;
   localparam lsu_state_t StIdle    = 2'd0;
   localparam lsu_state_t StAccess  = 2'd1;
   localparam lsu_state_t StCapture = 2'd2;
   localparam lsu_state_t StResp    = 2'd3;

endpackage

// File: rtl/lsu_decode.sv
// Combinational decode of funct3/we/address into a data_mem access encoding and fault code.
// Faulting requests always decode to EnNone so they can never reach memory.
module lsu_decode
   import lsu_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       we,
   input  logic [1:0] addr_lo,
   output logic [3:0] mem_en,
   output logic [1:0] fault
);

   logic [3:0] en_raw;

   always_comb begin
      en_raw = EnNone;
      case (funct3)
         F3Byte:  en_raw = we ? EnSb : EnLb;
         F3Half:  en_raw = we ? EnSh : EnLh;
         F3Word:  en_raw = we ? EnSw : EnLw;
         F3ByteU: en_raw = we ? EnNone : EnLbu;
         F3HalfU: en_raw = we ? EnNone : EnLhu;
         default: en_raw = EnNone;
      endcase
   end

   always_comb begin
      fault  = FaultNone;
      mem_en = en_raw;
      if (en_raw == EnNone) begin
         fault = FaultIllegal;
      end else if ((en_raw[1:0] == SizeHalf && addr_lo[0]) ||
                   (en_raw[1:0] == SizeWord && addr_lo != 2'b00)) begin
         fault = FaultMisalign;
      end
      if (fault != FaultNone) mem_en = EnNone;
   end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage LSU: one load/store per transaction, drives data_mem for one (store) or two
// (load) cycles and holds a registered response until write-back takes it.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [4:0]        req_rd,
   input  logic              flush,
   output logic [3:0]        mem_en,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_is_load,
   output logic [4:0]        rsp_rd,
   output logic [DATA_W-1:0] rsp_data,
   output logic [1:0]        rsp_fault
);

   lsu_state_t        state_q, state_d;
   logic [3:0]        en_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              is_load_q;
   logic [4:0]        rd_q;
   logic [DATA_W-1:0] data_q;
   logic [1:0]        fault_q;

   logic [3:0] dec_en;
   logic [1:0] dec_fault;
   logic       accept;

   lsu_decode u_decode (
      .funct3  (req_funct3),
      .we      (req_we),
      .addr_lo (req_addr[1:0]),
      .mem_en  (dec_en),
      .fault   (dec_fault)
   );

   assign req_ready = (state_q == StIdle);
   assign accept    = req_ready && req_valid && !flush;

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle: begin
            if (accept) state_d = (dec_fault != FaultNone) ? StResp : StAccess;
         end
         // flush is deliberately ignored here so a started memory operation always completes
         StAccess:  state_d = en_q[2] ? StResp : StCapture;
         StCapture: state_d = flush ? StIdle : StResp;
         StResp: begin
            if (flush || rsp_ready) state_d = StIdle;
         end
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         en_q      <= EnNone;
         addr_q    <= '0;
         wdata_q   <= '0;
         is_load_q <= 1'b0;
         rd_q      <= '0;
         data_q    <= '0;
         fault_q   <= FaultNone;
      end else begin
         state_q <= state_d;
         if (accept) begin
            en_q      <= dec_en;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            is_load_q <= !req_we;
            rd_q      <= req_we ? 5'd0 : req_rd;
            data_q    <= '0;
            fault_q   <= dec_fault;
         end
         if (state_q == StCapture) data_q <= mem_rdata;
      end
   end

   always_comb begin
      mem_en    = EnNone;
      mem_addr  = '0;
      mem_wdata = '0;
      if (state_q == StAccess || state_q == StCapture) begin
         mem_en   = en_q;
         mem_addr = addr_q;
      end
      if (state_q == StAccess) mem_wdata = wdata_q;
   end

   assign rsp_valid   = (state_q == StResp);
   assign rsp_is_load = is_load_q;
   assign rsp_rd      = rd_q;
   assign rsp_data    = data_q;
   assign rsp_fault   = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: behavioural data_mem stand-in, table vectors, random traffic
// against a byte-array reference model, and hand-written flush/backpressure/reset sequences.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        flush = 1'b0;
   logic [3:0]  mem_en;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic        rsp_is_load;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_fault;

   int total = 0;
   int bad = 0;
   int wr_edges = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_we      (req_we),
      .req_funct3  (req_funct3),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rd      (req_rd),
      .flush       (flush),
      .mem_en      (mem_en),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_is_load (rsp_is_load),
      .rsp_rd      (rsp_rd),
      .rsp_data    (rsp_data),
      .rsp_fault   (rsp_fault)
   );

   // data_mem stand-in: little-endian byte array, extension done here per mem_en[3]
   logic [7:0] dmem [256];
   logic [7:0] ra;

   always_comb begin
      mem_rdata = '0;
      ra = mem_addr[7:0];
      case (mem_en[1:0])
         2'b11: mem_rdata = {dmem[ra+8'd3], dmem[ra+8'd2], dmem[ra+8'd1], dmem[ra]};
         2'b10: mem_rdata = {{16{mem_en[3] & dmem[ra+8'd1][7]}}, dmem[ra+8'd1], dmem[ra]};
         2'b01: mem_rdata = {{24{mem_en[3] & dmem[ra][7]}}, dmem[ra]};
         default: mem_rdata = '0;
      endcase
   end

   always @(posedge clk) begin
      if (mem_en[2]) begin
         wr_edges <= wr_edges + 1;
         dmem[mem_addr[7:0]] <= mem_wdata[7:0];
         if (mem_en[1]) dmem[mem_addr[7:0]+8'd1] <= mem_wdata[15:8];
         if (mem_en[1:0] == 2'b11) begin
            dmem[mem_addr[7:0]+8'd2] <= mem_wdata[23:16];
            dmem[mem_addr[7:0]+8'd3] <= mem_wdata[31:24];
         end
      end
   end

   // Reference model: byte values as plain integers
   int ref_mem [256];

   function automatic int size_of(input logic [2:0] f3);
      int low = int'(f3) % 4;
      return (low == 0) ? 1 : ((low == 1) ? 2 : 4);
   endfunction

   function automatic logic [1:0] model_fault(input logic we, input logic [2:0] f3,
                                              input logic [31:0] addr);
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7 || (we && f3 >= 3'd4)) return 2'b10;
      if (int'(addr % 32'(size_of(f3))) != 0) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [3:0] model_en(input logic we, input logic [2:0] f3);
      case ({we, f3})
         4'b1010: return 4'b0111;
         4'b1001: return 4'b0110;
         4'b1000: return 4'b0101;
         4'b0010: return 4'b1011;
         4'b0001: return 4'b1010;
         4'b0101: return 4'b0010;
         4'b0000: return 4'b1001;
         4'b0100: return 4'b0001;
         default: return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
      int a = int'(addr % 256);
      longint v = 0;
      for (int i = 0; i < size_of(f3); i++) v += longint'(ref_mem[(a + i) % 256]) << (8 * i);
      if (f3 == 3'd0 && v > 127) v -= 256;
      if (f3 == 3'd1 && v > 32767) v -= 65536;
      return v[31:0];
   endfunction

   task automatic model_store(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata);
      longint w = longint'(wdata);
      for (int i = 0; i < size_of(f3); i++)
         ref_mem[(int'(addr % 256) + i) % 256] = int'((w >> (8 * i)) % 256);
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h expected=%h", name, got, exp);
      end
   endtask

   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd,
                         output int lat, output logic [31:0] data, output logic [1:0] fault,
                         output logic [4:0] grd, output logic gload, output int en_cycles,
                         output logic [3:0] en_seen, output int rr_bad);
      lat = -1; data = '0; fault = '0; grd = '0; gload = 1'b0;
      en_cycles = 0; en_seen = '0; rr_bad = 0;
      @(negedge clk);
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
      req_wdata = wdata; req_rd = rd;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (req_ready) rr_bad++;
         if (mem_en != 4'b0) begin
            en_cycles++;
            en_seen = mem_en;
         end
         if (rsp_valid) begin
            lat = k; data = rsp_data; fault = rsp_fault; grd = rsp_rd; gload = rsp_is_load;
            break;
         end
      end
      @(posedge clk);
   endtask

   task automatic check_txn(input string tag, input logic we, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [4:0] rd, input logic [1:0] efault,
                            input logic [31:0] edata, input logic [3:0] een, input int elat);
      int lat, enc, rrb, wb;
      logic [31:0] d;
      logic [1:0] f;
      logic [4:0] r;
      logic ld;
      logic [3:0] es;
      int exp_enc;
      wb = wr_edges;
      do_txn(we, f3, addr, wdata, rd, lat, d, f, r, ld, enc, es, rrb);
      @(negedge clk);
      exp_enc = (efault != 2'b00) ? 0 : (we ? 1 : 2);
      chk({tag, " latency"}, 32'(lat), 32'(elat));
      chk({tag, " fault"}, 32'(f), 32'(efault));
      chk({tag, " data"}, d, edata);
      chk({tag, " rd"}, 32'(r), we ? 32'd0 : 32'(rd));
      chk({tag, " is_load"}, 32'(ld), 32'(!we));
      chk({tag, " mem_en"}, 32'(es), 32'(een));
      chk({tag, " mem_en cycles"}, 32'(enc), 32'(exp_enc));
      chk({tag, " write edges"}, 32'(wr_edges - wb),
          (we && efault == 2'b00) ? 32'd1 : 32'd0);
      chk({tag, " req_ready low while busy"}, 32'(rrb), 32'd0);
      if (we && efault == 2'b00) model_store(f3, addr, wdata);
   endtask

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [4:0]  rd;
      logic [1:0]  fault;
      logic [31:0] data;
      logic [3:0]  en;
      int          lat;
   } vec_t;

   vec_t vt [15];

   task automatic check_reset_values(input string tag);
      chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
      chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
      chk({tag, " mem_addr"}, mem_addr, 32'd0);
      chk({tag, " mem_wdata"}, mem_wdata, 32'd0);
      chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, " rsp_data"}, rsp_data, 32'd0);
      chk({tag, " rsp_rd"}, 32'(rsp_rd), 32'd0);
      chk({tag, " rsp_fault"}, 32'(rsp_fault), 32'd0);
      chk({tag, " rsp_is_load"}, 32'(rsp_is_load), 32'd0);
   endtask

   initial begin
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [1:0]  ef;
      logic [31:0] exp_d;
      logic [4:0]  rd0;
      int          seen;

      for (int i = 0; i < 256; i++) begin
         dmem[i] = 8'h00;
         ref_mem[i] = 0;
      end

      vt[0]  = '{1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd3,  2'b00, 32'h0,        4'b0111, 2};
      vt[1]  = '{1'b0, 3'b010, 32'h10, 32'h0,        5'd4,  2'b00, 32'hDEADBEEF, 4'b1011, 3};
      vt[2]  = '{1'b1, 3'b000, 32'h21, 32'h12345680, 5'd1,  2'b00, 32'h0,        4'b0101, 2};
      vt[3]  = '{1'b0, 3'b000, 32'h21, 32'h0,        5'd5,  2'b00, 32'hFFFFFF80, 4'b1001, 3};
      vt[4]  = '{1'b0, 3'b100, 32'h21, 32'h0,        5'd6,  2'b00, 32'h00000080, 4'b0001, 3};
      vt[5]  = '{1'b0, 3'b001, 32'h03, 32'h0,        5'd7,  2'b01, 32'h0,        4'b0000, 1};
      vt[6]  = '{1'b0, 3'b010, 32'h02, 32'h0,        5'd8,  2'b01, 32'h0,        4'b0000, 1};
      vt[7]  = '{1'b1, 3'b101, 32'h20, 32'h1111,     5'd2,  2'b10, 32'h0,        4'b0000, 1};
      vt[8]  = '{1'b1, 3'b001, 32'h22, 32'h5555ABCD, 5'd2,  2'b00, 32'h0,        4'b0110, 2};
      vt[9]  = '{1'b0, 3'b101, 32'h22, 32'h0,        5'd10, 2'b00, 32'h0000ABCD, 4'b0010, 3};
      vt[10] = '{1'b0, 3'b001, 32'h22, 32'h0,        5'd11, 2'b00, 32'hFFFFABCD, 4'b1010, 3};
      vt[11] = '{1'b0, 3'b011, 32'h00, 32'h0,        5'd12, 2'b10, 32'h0,        4'b0000, 1};
      vt[12] = '{1'b0, 3'b010, 32'h20, 32'h0,        5'd13, 2'b00, 32'hABCD8000, 4'b1011, 3};
      vt[13] = '{1'b1, 3'b010, 32'h11, 32'h77,       5'd1,  2'b01, 32'h0,        4'b0000, 1};
      vt[14] = '{1'b1, 3'b100, 32'h24, 32'h77,       5'd1,  2'b10, 32'h0,        4'b0000, 1};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset");

      for (int i = 0; i < 15; i++)
         check_txn($sformatf("vec%0d", i), vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata,
                   vt[i].rd, vt[i].fault, vt[i].data, vt[i].en, vt[i].lat);

      for (int i = 0; i < 150; i++) begin
         we = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         addr = 32'($urandom_range(0, 63));
         wdata = $urandom;
         rd0 = 5'($urandom_range(0, 31));
         ef = model_fault(we, f3, addr);
         exp_d = (!we && ef == 2'b00) ? model_load(f3, addr) : 32'h0;
         check_txn($sformatf("rnd%0d", i), we, f3, addr, wdata, rd0, ef, exp_d,
                   (ef == 2'b00) ? model_en(we, f3) : 4'b0000,
                   (ef != 2'b00) ? 1 : (we ? 2 : 3));
      end

      // Backpressure: response held for 5 cycles with rsp_ready low
      @(negedge clk);
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd7;
      @(posedge clk);
      #1 req_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 10 && seen == 0; k++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1;
      end
      chk("bp rsp_valid reached", 32'(seen), 32'd1);
      for (int k = 0; k < 5; k++) begin
         chk($sformatf("bp hold%0d rsp_valid", k), 32'(rsp_valid), 32'd1);
         chk($sformatf("bp hold%0d rsp_data", k), rsp_data, model_load(3'b010, 32'h10));
         chk($sformatf("bp hold%0d rsp_rd", k), 32'(rsp_rd), 32'd7);
         chk($sformatf("bp hold%0d req_ready", k), 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp release rsp_valid", 32'(rsp_valid), 32'd0);
      chk("bp release req_ready", 32'(req_ready), 32'd1);

      // Flush during a store's ACCESS cycle must not cancel the write
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30;
      req_wdata = 32'h12345678; req_rd = 5'd0;
      @(posedge clk);
      #1 req_valid = 1'b0; flush = 1'b1;
      @(negedge clk);
      chk("flush access mem_en", 32'(mem_en), 32'h7);
      @(posedge clk);
      #1 flush = 1'b0;
      @(negedge clk);
      chk("flush access rsp_valid", 32'(rsp_valid), 32'd1);
      model_store(3'b010, 32'h30, 32'h12345678);
      check_txn("flush access readback", 1'b0, 3'b010, 32'h30, 32'h0, 5'd14, 2'b00,
                32'h12345678, 4'b1011, 3);

      // Flush in CAPTURE drops the response entirely
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30; req_rd = 5'd9;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk);
      #1 flush = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("flush capture rsp_valid%0d", k), 32'(rsp_valid), 32'd0);
         chk($sformatf("flush capture req_ready%0d", k), 32'(req_ready), 32'd1);
      end

      // Flush in IDLE blocks acceptance
      req_valid = 1'b1; flush = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk("flush idle req_ready", 32'(req_ready), 32'd1);
      chk("flush idle mem_en", 32'(mem_en), 32'd0);

      // Reset during CAPTURE: outputs return to reset values
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h30; req_rd = 5'd9;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values("rst capture");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
